pic_command_sequencer: RTL and testbench

//  Write-side control stage of the 8259 PIC; sits directly downstream of the data bus buffer.

---
 rtl/pic_pkg.sv | 46 ++++
 rtl/pic_sync.sv | 24 ++
 rtl/pic_command_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pic_command_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 write-side command sequencer: state
// encoding, OCW2 command codes and ICW/OCW bit positions.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_e;

  typedef enum logic [2:0] {
    OCW2_ROT_AEOI_CLR = 3'b000,
    OCW2_NSEOI        = 3'b001,
    OCW2_NOP          = 3'b010,
    OCW2_SEOI         = 3'b011,
    OCW2_ROT_AEOI_SET = 3'b100,
    OCW2_ROT_NSEOI    = 3'b101,
    OCW2_SET_PRI      = 3'b110,
    OCW2_ROT_SEOI     = 3'b111
  } pic_ocw2_e;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  localparam int OCW_SEL   = 3;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_POLL = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  function automatic logic is_icw1(input logic a0, input logic [7:0] d);
    return (a0 == 1'b0) && d[ICW1_SEL];
  endfunction

endpackage

// File: rtl/pic_sync.sv
// STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module pic_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // shift the raw level through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pic_command_sequencer.sv
// 8259 write-side control: ICW1..ICW4 initialisation and OCW1/2/3 decode.
// Build option PIC_AEOI_EN: when defined, aeoi follows ICW4 D1; otherwise aeoi is 0.
module pic_command_sequencer
  import pic_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IMR_RST     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] internal,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] icw3,
  output logic       aeoi,
  output logic       upm,
  output logic       sfnm,
  output logic       buf_mode,
  output logic       ms,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr,
  output logic       special_mask,
  output logic       poll_pending
);

  logic       wr_win_s, rd_win_s;
  logic       wr_sync_s, rd_sync_s;
  logic       wr_prev_q, rd_prev_q;
  logic       commit_s, rd_end_s;
  logic       hold_a0_q;
  logic [7:0] hold_data_q;

  pic_state_e state_q;
  pic_ocw2_e  ocw2_cmd_q;
  logic       ic4_q, init_done_q, ltim_q, sngl_q;
  logic [4:0] vector_base_q;
  logic [7:0] icw3_q, imr_q;
  logic       aeoi_q, upm_q, sfnm_q, buf_mode_q, ms_q;
  logic       ocw2_valid_q;
  logic [2:0] ocw2_level_q;
  logic       read_isr_q, special_mask_q, poll_q;

  // a write overlapping a read wins, so the read window excludes wr_n low
  assign wr_win_s = ~cs_n & ~wr_n;
  assign rd_win_s = ~cs_n & ~rd_n & wr_n;

  pic_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst_n(rst_n), .d(wr_win_s), .q(wr_sync_s)
  );

  pic_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst_n(rst_n), .d(rd_win_s), .q(rd_sync_s)
  );

  assign commit_s = wr_prev_q & ~wr_sync_s;
  assign rd_end_s = rd_prev_q & ~rd_sync_s;

  // edge history of both windows and the byte/address latched while writing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      hold_a0_q   <= 1'b0;
      hold_data_q <= 8'h00;
    end else begin
      wr_prev_q <= wr_sync_s;
      rd_prev_q <= rd_sync_s;
      if (wr_win_s) begin
        hold_a0_q   <= a0;
        hold_data_q <= internal;
      end else begin
        hold_a0_q   <= hold_a0_q;
        hold_data_q <= hold_data_q;
      end
    end
  end

  // initialisation FSM and command decode, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_UNINIT;
      ic4_q          <= 1'b0;
      init_done_q    <= 1'b0;
      ltim_q         <= 1'b0;
      sngl_q         <= 1'b0;
      vector_base_q  <= 5'd0;
      icw3_q         <= 8'h00;
      aeoi_q         <= 1'b0;
      upm_q          <= 1'b0;
      sfnm_q         <= 1'b0;
      buf_mode_q     <= 1'b0;
      ms_q           <= 1'b0;
      imr_q          <= IMR_RST;
      ocw2_valid_q   <= 1'b0;
      ocw2_cmd_q     <= OCW2_ROT_AEOI_CLR;
      ocw2_level_q   <= 3'd0;
      read_isr_q     <= 1'b0;
      special_mask_q <= 1'b0;
      poll_q         <= 1'b0;
    end else begin
      ocw2_valid_q <= 1'b0;
      if (rd_end_s) begin
        poll_q <= 1'b0;
      end
      if (commit_s) begin
        if (is_icw1(hold_a0_q, hold_data_q)) begin
          ltim_q         <= hold_data_q[ICW1_LTIM];
          sngl_q         <= hold_data_q[ICW1_SNGL];
          ic4_q          <= hold_data_q[ICW1_IC4];
          imr_q          <= IMR_RST;
          special_mask_q <= 1'b0;
          read_isr_q     <= 1'b0;
          poll_q         <= 1'b0;
          aeoi_q         <= 1'b0;
          upm_q          <= 1'b0;
          sfnm_q         <= 1'b0;
          buf_mode_q     <= 1'b0;
          ms_q           <= 1'b0;
          init_done_q    <= 1'b0;
          state_q        <= ST_WAIT_ICW2;
        end else if (!hold_a0_q) begin
          if (state_q == ST_READY) begin
            if (!hold_data_q[OCW_SEL]) begin
              ocw2_cmd_q   <= pic_ocw2_e'(hold_data_q[7:5]);
              ocw2_level_q <= hold_data_q[2:0];
              ocw2_valid_q <= 1'b1;
            end else begin
              if (hold_data_q[OCW3_RR]) read_isr_q <= hold_data_q[OCW3_RIS];
              if (hold_data_q[OCW3_ESMM]) special_mask_q <= hold_data_q[OCW3_SMM];
              // placed after the read-end clear so a same-cycle poll set wins
              if (hold_data_q[OCW3_POLL]) poll_q <= 1'b1;
            end
          end
        end else begin
          case (state_q)
            ST_UNINIT: begin
              state_q <= ST_UNINIT;
            end
            ST_WAIT_ICW2: begin
              vector_base_q <= hold_data_q[7:3];
              if (!sngl_q) begin
                state_q <= ST_WAIT_ICW3;
              end else if (ic4_q) begin
                state_q <= ST_WAIT_ICW4;
              end else begin
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
              end
            end
            ST_WAIT_ICW3: begin
              icw3_q <= hold_data_q;
              if (ic4_q) begin
                state_q <= ST_WAIT_ICW4;
              end else begin
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
              end
            end
            ST_WAIT_ICW4: begin
`ifdef PIC_AEOI_EN
              aeoi_q      <= hold_data_q[ICW4_AEOI];
`else
              aeoi_q      <= 1'b0;
`endif
              upm_q       <= hold_data_q[ICW4_UPM];
              ms_q        <= hold_data_q[ICW4_MS];
              buf_mode_q  <= hold_data_q[ICW4_BUF];
              sfnm_q      <= hold_data_q[ICW4_SFNM];
              state_q     <= ST_READY;
              init_done_q <= 1'b1;
            end
            ST_READY: begin
              imr_q <= hold_data_q;
            end
            default: begin
              state_q     <= ST_UNINIT;
              init_done_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign init_done    = init_done_q;
  assign ltim         = ltim_q;
  assign sngl         = sngl_q;
  assign vector_base  = vector_base_q;
  assign icw3         = icw3_q;
  assign aeoi         = aeoi_q;
  assign upm          = upm_q;
  assign sfnm         = sfnm_q;
  assign buf_mode     = buf_mode_q;
  assign ms           = ms_q;
  assign imr          = imr_q;
  assign ocw2_valid   = ocw2_valid_q;
  assign ocw2_cmd     = ocw2_cmd_q;
  assign ocw2_level   = ocw2_level_q;
  assign read_isr     = read_isr_q;
  assign special_mask = special_mask_q;
  assign poll_pending = poll_q;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Scoreboard bench for pic_command_sequencer: directed init/OCW sequences plus
// random bus cycles checked against a step-list reference model.
module tb_pic_command_sequencer;

  localparam logic [7:0] IMR_RST = 8'h00;
  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
  logic [7:0] internal = 8'h00;
  logic       init_done, ltim, sngl, aeoi, upm, sfnm, buf_mode, ms;
  logic [4:0] vector_base;
  logic [7:0] icw3, imr;
  logic       ocw2_valid, read_isr, special_mask, poll_pending;
  logic [2:0] ocw2_cmd, ocw2_level;

  int total = 0;
  int bad = 0;

  pic_command_sequencer #(.SYNC_STAGES(2), .IMR_RST(IMR_RST)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .internal(internal), .init_done(init_done), .ltim(ltim), .sngl(sngl),
    .vector_base(vector_base), .icw3(icw3), .aeoi(aeoi), .upm(upm), .sfnm(sfnm),
    .buf_mode(buf_mode), .ms(ms), .imr(imr), .ocw2_valid(ocw2_valid),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .read_isr(read_isr),
    .special_mask(special_mask), .poll_pending(poll_pending)
  );

  always #5 clk = ~clk;

  // reference model: ICW1 schedules a list of remaining init steps
  bit         m_started;
  int         m_steps[$];
  logic       m_ltim, m_sngl, m_aeoi, m_upm, m_sfnm, m_buf, m_ms;
  logic [4:0] m_vb;
  logic [7:0] m_icw3, m_imr;
  logic [2:0] m_cmd, m_lvl;
  logic       m_ris, m_smm, m_poll;

  logic [37:0] exp_q[$];
  logic [5:0]  ocw2_q[$];
  event        chk_ev;

  function automatic logic [37:0] model_pack();
    logic m_init;
    m_init = m_started && (m_steps.size() == 0);
    return {m_init, m_ltim, m_sngl, m_vb, m_icw3, m_aeoi, m_upm, m_sfnm, m_buf, m_ms,
            m_imr, m_cmd, m_lvl, m_ris, m_smm, m_poll};
  endfunction

  function automatic logic [37:0] dut_pack();
    return {init_done, ltim, sngl, vector_base, icw3, aeoi, upm, sfnm, buf_mode, ms,
            imr, ocw2_cmd, ocw2_level, read_isr, special_mask, poll_pending};
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_steps.delete();
    {m_ltim, m_sngl, m_aeoi, m_upm, m_sfnm, m_buf, m_ms} = 7'd0;
    m_vb = 5'd0; m_icw3 = 8'h00; m_imr = IMR_RST;
    m_cmd = 3'd0; m_lvl = 3'd0; m_ris = 1'b0; m_smm = 1'b0; m_poll = 1'b0;
  endtask

  task automatic model_write(input logic a, input logic [7:0] d);
    if (!a && d[4]) begin
      m_started = 1'b1;
      m_ltim = d[3]; m_sngl = d[1];
      m_imr = IMR_RST; m_smm = 1'b0; m_ris = 1'b0; m_poll = 1'b0;
      {m_aeoi, m_upm, m_sfnm, m_buf, m_ms} = 5'd0;
      m_steps.delete();
      m_steps.push_back(2);
      if (!d[1]) m_steps.push_back(3);
      if (d[0]) m_steps.push_back(4);
    end else if (!m_started) begin
      m_started = 1'b0;
    end else if (m_steps.size() != 0) begin
      if (a) begin
        if (m_steps[0] == 2) m_vb = d[7:3];
        else if (m_steps[0] == 3) m_icw3 = d;
        else begin
`ifdef PIC_AEOI_EN
          m_aeoi = d[1];
`else
          m_aeoi = 1'b0;
`endif
          m_upm = d[0]; m_ms = d[2]; m_buf = d[3]; m_sfnm = d[4];
        end
        void'(m_steps.pop_front());
      end
    end else if (a) begin
      m_imr = d;
    end else if (!d[3]) begin
      m_cmd = d[7:5]; m_lvl = d[2:0];
      ocw2_q.push_back({d[7:5], d[2:0]});
    end else begin
      if (d[1]) m_ris = d[0];
      if (d[6]) m_smm = d[5];
      if (d[2]) m_poll = 1'b1;
    end
  endtask

  task automatic expect_now();
    exp_q.push_back(model_pack());
    -> chk_ev;
  endtask

  // kind: 0 normal write, 1 write with cs_n high, 2 write overlapping a read
  task automatic bus_write(input logic a, input logic [7:0] d, input int kind);
    int n;
    n = $urandom_range(2, 4);
    @(negedge clk);
    a0 = a; internal = d; wr_n = 1'b0;
    cs_n = (kind == 1) ? 1'b1 : 1'b0;
    rd_n = (kind == 2) ? 1'b0 : 1'b1;
    repeat (n) @(negedge clk);
    wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
    internal = 8'($urandom); a0 = 1'($urandom);
    if (kind != 1) model_write(a, d);
    repeat (SETTLE) @(negedge clk);
    expect_now();
  endtask

  task automatic bus_read();
    int n;
    n = $urandom_range(2, 3);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0;
    repeat (n) @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1;
    m_poll = 1'b0;
    repeat (SETTLE) @(negedge clk);
    expect_now();
  endtask

  // output scoreboard: compare the full output image on each check request
  initial begin
    logic [37:0] e;
    forever begin
      @(chk_ev);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL outs: check requested with empty expectation queue");
      end else begin
        e = exp_q.pop_front();
        if (dut_pack() !== e) begin
          bad++;
          $display("FAIL outs: got=%h exp=%h (init,ltim,sngl,vb,icw3,icw4x5,imr,cmd,lvl,ris,smm,poll)",
                   dut_pack(), e);
        end
      end
    end
  end

  // OCW2 strobe monitor: each pulse must be one clk wide and match the next expected command
  initial begin
    logic       prev_v;
    logic [5:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (ocw2_valid) begin
        total++;
        if (prev_v) begin
          bad++;
          $display("FAIL ocw2_width: strobe high for more than 1 clk");
        end else if (ocw2_q.size() == 0) begin
          bad++;
          $display("FAIL ocw2_unexpected: got=%b/%b with no OCW2 issued", ocw2_cmd, ocw2_level);
        end else begin
          e = ocw2_q.pop_front();
          if ({ocw2_cmd, ocw2_level} !== e) begin
            bad++;
            $display("FAIL ocw2_fields: got=%b exp=%b", {ocw2_cmd, ocw2_level}, e);
          end
        end
      end
      prev_v = ocw2_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [7:0] d;
    model_reset();
    repeat (3) @(negedge clk);
    expect_now();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_now();

    bus_write(1'b1, 8'hFF, 0);
    bus_write(1'b0, 8'h13, 0);
    bus_write(1'b1, 8'h20, 0);
    bus_write(1'b1, 8'h03, 0);
    bus_write(1'b0, 8'h11, 0);
    bus_write(1'b1, 8'h08, 0);
    bus_write(1'b1, 8'h04, 0);
    bus_write(1'b1, 8'h01, 0);
    bus_write(1'b1, 8'hFB, 0);
    bus_write(1'b0, 8'h20, 0);
    bus_write(1'b0, 8'h0B, 0);
    bus_write(1'b0, 8'h68, 0);
    bus_write(1'b0, 8'h0C, 0);
    bus_write(1'b1, 8'h5A, 2);
    bus_write(1'b1, 8'h33, 1);
    bus_read();
    bus_write(1'b0, 8'h11, 0);
    bus_write(1'b1, 8'h40, 0);
    bus_write(1'b0, 8'h20, 0);
    bus_write(1'b0, 8'h13, 0);
    bus_write(1'b1, 8'h48, 0);

    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    expect_now();
    @(negedge clk);
    rst_n = 1'b1;

    bus_write(1'b0, 8'h17, 0);
    bus_write(1'b1, 8'hF8, 0);
    bus_write(1'b1, 8'h1F, 0);
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 99);
      d = 8'($urandom);
      if (op < 10) bus_write(1'b0, d | 8'h10, 0);
      else if (op < 50) bus_write(1'b1, d, 0);
      else if (op < 75) bus_write(1'b0, d & 8'hEF, 0);
      else if (op < 85) bus_read();
      else if (op < 90) bus_write(1'($urandom), d, 1);
      else bus_write(1'($urandom), d, 2);
    end

    repeat (4) @(negedge clk);
    total++;
    if (ocw2_q.size() != 0) begin
      bad++;
      $display("FAIL ocw2_missing: got=%0d strobes outstanding, exp=0", ocw2_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
